sha256_msg_feeder: RTL and testbench
====================================

// Module: sha256_msg_feeder
// PURPOSE
//  Core-side transmitter of the SHA-256 word interface. It accepts a raw message as 32-bit words
//  over a valid/ready stream and applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit bit length).
//  Per 512-bit block it drives the message-expansion unit: 16 LOAD beats (code 3'b010), then 64 EXPAND
//  beats (code 3'b011). It then waits for the compression round to report done.
// PARAMETERS
//  DATA_WIDTH  32  word width; only 32 is supported
//  LEN_WIDTH   64  message bit-length counter width; appended as two words, high word first
// PORTS
//  clk             in   1   single clock, rising edge
//  rst             in   1   synchronous, active-high reset
//  start_in        in   1   pulse in IDLE: begin new message, clear length counter
//  msg_valid_in    in   1   msg_data_in valid
//  msg_ready_out   out  1   feeder accepts a word this cycle (valid&&ready = beat)
//  msg_data_in     in   32  big-endian message word; valid bytes left-aligned
//  msg_last_in     in   1   beat carries final message word
//  msg_bytes_in    in   3   valid bytes in last beat, 0..4 (0 = empty message / no data)
//  fsm_core_out    out  3   000 IDLE, 001 HOLD, 010 LOAD, 011 EXPAND, 100 WAIT, 101 DONE
//  core_count_out  out  7   word index: 0..15 in LOAD, 0..63 in EXPAND
//  me_data_out     out  32  word for the expansion unit; meaningful only in LOAD
//  block_first_out out  1   high through LOAD/EXPAND/WAIT of a message's first block (selects IV)
//  comp_done_in    in   1   compression finished the block; sampled only in WAIT
//  msg_done_out    out  1   one-cycle pulse: last block's comp_done_in accepted
//  busy_out        out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, length=0, pad flags cleared. Reset mid-message aborts silently; no done pulse.
//  IDLE -> LOAD on start_in. start_in is ignored outside IDLE.
//  LOAD: at most one word per cycle, registered outputs. A word is emitted with code 010 at count k,
//    then count increments. Sources: input beat, then pad word, zero words, len_hi at k=14, len_lo at k=15.
//    Input starved (no pad word pending): code=001 HOLD, count/data hold; no word is lost or repeated.
//    msg_ready_out=1 only in LOAD while the message is not finished and k<=15.
//  Length counter: += 8*bytes per accepted beat (32 for non-last), LEN_WIDTH bits. It wraps on overflow.
//  Padding on last beat:
//    bytes 1..3: data keeps the valid bytes, byte[bytes]=0x80, rest 0.
//    bytes 0: word=0x80000000.
//    bytes 4: word as-is; next slot=0x80000000.
//    Pad marker at k<=13: zeros to k=13, then length at 14/15.
//    Pad marker at k=14/15: zeros to 15; next block is zeros 0..13 plus length.
//  After k=15: EXPAND, count 0..63 one per cycle, code 011, me_data_out=0. Then WAIT, count=0.
//  WAIT: code 100 until comp_done_in.
//    More data or pad remains: -> LOAD, block_first_out=0.
//    Else -> DONE for one cycle (msg_done_out=1) -> IDLE.
//  comp_done_in is ignored outside WAIT. msg_valid_in is ignored outside LOAD.
//  msg_last with k=15 full word (bytes 4): marker goes to next block's k=0.
// STRUCTURE
//  Package sha256_pkg: FSM code localparams (shared with the expansion unit/core), PAD_MARKER=32'h8000_0000.
//  One sub-module: sha256_pad_word (comb): data, bytes -> padded word. The FSM and counters stay here.
// TESTING
//  "abc": start; beat 0x61626300 last bytes=3 -> LOAD 0x61626380, zeros, W14=0, W15=0x18; one block; done pulse.
//  Empty: start; beat last bytes=0 -> W0=0x80000000, W1..W15=0, one block, msg_done_out after comp_done_in.
//  56-byte msg (14 full words, last bytes=4) -> blk1 W14=0x80000000, W15=0;
//    blk2 W0..13=0, W14=0, W15=0x1C0; block_first_out 1 then 0.
//  Stall: drop msg_valid_in for 3 cycles at k=5 -> code 001, count stays 5, no duplicate 010 beat.
//    Data resumes intact.
//  WAIT hold: delay comp_done_in 10 cycles -> code 100, count 0, ready 0. Pulse during EXPAND -> ignored.
//  Reset asserted at EXPAND count 30 -> next cycle all outputs 0, IDLE. A new "abc" run then matches test 1.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 datapath.
// Core interface codes are shared with the message-expansion unit and the compression core.
// The feeder's internal FSM state type is also defined here.
package sha256_pkg;
  localparam logic [2:0] CORE_IDLE   = 3'b000;
  localparam logic [2:0] CORE_HOLD   = 3'b001;
  localparam logic [2:0] CORE_LOAD   = 3'b010;
  localparam logic [2:0] CORE_EXPAND = 3'b011;
  localparam logic [2:0] CORE_WAIT   = 3'b100;
  localparam logic [2:0] CORE_DONE   = 3'b101;

  localparam logic [31:0] PAD_MARKER = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXPAND,
    S_WAIT,
    S_DONE
  } feed_state_t;
endpackage

// File: rtl/sha256_pad_word.sv
// Combinational padding of one message word.
//   data  : big-endian word, valid bytes left-aligned
//   bytes : valid bytes in the final beat (0..4)
//   last  : beat carries the final message word
//   word  : word as emitted to the expansion unit
// A non-final word, or a final word with 4 valid bytes, passes through unchanged.
// In the 4-byte case the marker goes in the following slot, which the feeder handles.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  bytes,
  input  logic        last,
  output logic [31:0] word
);
  always_comb begin
    word = data;
    if (last) begin
      case (bytes)
        3'd0:    word = PAD_MARKER;
        3'd1:    word = {data[31:24], 24'h80_0000};
        3'd2:    word = {data[31:16], 16'h8000};
        3'd3:    word = {data[31:8], 8'h80};
        default: word = data;
      endcase
    end
  end
endmodule

// File: rtl/sha256_msg_feeder.sv
// SHA-256 message feeder: pads a raw 32-bit word stream and drives the expansion unit.
// Each 512-bit block is sent as 16 LOAD beats followed by 64 EXPAND beats.
// The feeder then waits in WAIT until the compression core reports comp_done_in.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start_in                    begin a new message (IDLE only)
//   msg_valid_in/msg_ready_out  input word handshake
//   msg_data_in/msg_last_in/msg_bytes_in  word, final flag, valid bytes in final beat
//   fsm_core_out/core_count_out/me_data_out  registered code/index/word to expansion unit
//   block_first_out             first block of the message (IV select)
//   comp_done_in                compression done (sampled in WAIT)
//   msg_done_out                one-cycle pulse when the last block completes
//   busy_out                    not idle
// Core outputs are registered. They show the action taken at the previous clock edge.
module sha256_msg_feeder
  import sha256_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_in,
  input  logic                  msg_valid_in,
  output logic                  msg_ready_out,
  input  logic [DATA_WIDTH-1:0] msg_data_in,
  input  logic                  msg_last_in,
  input  logic [2:0]            msg_bytes_in,
  output logic [2:0]            fsm_core_out,
  output logic [6:0]            core_count_out,
  output logic [DATA_WIDTH-1:0] me_data_out,
  output logic                  block_first_out,
  input  logic                  comp_done_in,
  output logic                  msg_done_out,
  output logic                  busy_out
);
  feed_state_t           state_q, state_d;
  logic [3:0]            k_q, k_d;           // LOAD slot index
  logic [5:0]            e_q, e_d;           // EXPAND index
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  fin_q, fin_d;       // final beat accepted
  logic                  mpend_q, mpend_d;   // marker owed in its own slot
  logic                  lenok_q, lenok_d;   // marker already placed early enough for length at 14/15
  logic                  lend_q, lend_d;     // length words emitted
  logic                  first_q, first_d;
  logic [2:0]            code_q, code_d;
  logic [6:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] padded;
  logic [DATA_WIDTH-1:0] word;
  logic                  emit;

  sha256_pad_word u_pad (
    .data  (msg_data_in),
    .bytes (msg_bytes_in),
    .last  (msg_last_in),
    .word  (padded)
  );

  assign msg_ready_out   = (state_q == S_LOAD) && !fin_q;
  assign fsm_core_out    = code_q;
  assign core_count_out  = cnt_q;
  assign me_data_out     = data_q;
  assign block_first_out = first_q;
  assign msg_done_out    = done_q;
  assign busy_out        = (code_q != CORE_IDLE);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    e_d     = e_q;
    len_d   = len_q;
    fin_d   = fin_q;
    mpend_d = mpend_q;
    lenok_d = lenok_q;
    lend_d  = lend_q;
    first_d = first_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
    emit    = 1'b0;
    word    = '0;
    case (state_q)
      S_IDLE: begin
        code_d = CORE_IDLE;
        cnt_d  = '0;
        data_d = '0;
        if (start_in) begin
          state_d = S_LOAD;
          code_d  = CORE_HOLD;
          k_d     = '0;
          len_d   = '0;
          fin_d   = 1'b0;
          mpend_d = 1'b0;
          lenok_d = 1'b0;
          lend_d  = 1'b0;
          first_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (!fin_q) begin
          if (msg_valid_in) begin
            emit  = 1'b1;
            word  = padded;
            len_d = len_q + (msg_last_in ? LEN_WIDTH'({msg_bytes_in, 3'b000})
                                         : LEN_WIDTH'(32));
            if (msg_last_in) begin
              fin_d = 1'b1;
              if (msg_bytes_in >= 3'd4) mpend_d = 1'b1;
              else                      lenok_d = (k_q <= 4'd13);
            end
          end
        end else if (mpend_q) begin
          emit    = 1'b1;
          word    = PAD_MARKER;
          mpend_d = 1'b0;
          lenok_d = (k_q <= 4'd13);
        end else begin
          // Zero fill; the length occupies slots 14/15 once the marker fits.
          emit = 1'b1;
          if (lenok_q && k_q == 4'd14) word = len_q[LEN_WIDTH-1 -: DATA_WIDTH];
          if (lenok_q && k_q == 4'd15) begin
            word   = len_q[DATA_WIDTH-1:0];
            lend_d = 1'b1;
          end
        end
        if (emit) begin
          code_d = CORE_LOAD;
          cnt_d  = {3'b000, k_q};
          data_d = word;
          k_d    = k_q + 4'd1;
          if (k_q == 4'd15) begin
            state_d = S_EXPAND;
            e_d     = '0;
          end
        end else begin
          // Starved: advertise the pending slot, keep the last word on the bus.
          code_d = CORE_HOLD;
          cnt_d  = {3'b000, k_q};
        end
      end
      S_EXPAND: begin
        code_d = CORE_EXPAND;
        cnt_d  = {1'b0, e_q};
        data_d = '0;
        e_d    = e_q + 6'd1;
        if (e_q == 6'd63) state_d = S_WAIT;
      end
      S_WAIT: begin
        code_d = CORE_WAIT;
        cnt_d  = '0;
        data_d = '0;
        if (comp_done_in) begin
          first_d = 1'b0;
          if (fin_q && lend_q) begin
            state_d = S_DONE;
            code_d  = CORE_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
            code_d  = CORE_HOLD;
            k_d     = '0;
            // A marker placed in a previous block frees this block's slots 14/15.
            lenok_d = fin_q && !mpend_q;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        code_d  = CORE_IDLE;
        first_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      e_q     <= '0;
      len_q   <= '0;
      fin_q   <= 1'b0;
      mpend_q <= 1'b0;
      lenok_q <= 1'b0;
      lend_q  <= 1'b0;
      first_q <= 1'b0;
      code_q  <= CORE_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      e_q     <= e_d;
      len_q   <= len_d;
      fin_q   <= fin_d;
      mpend_q <= mpend_d;
      lenok_q <= lenok_d;
      lend_q  <= lend_d;
      first_q <= first_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Scoreboard bench for sha256_msg_feeder.
// A byte-level FIPS 180-4 padding model pushes expected LOAD words.
// A negedge monitor pops one entry per LOAD beat.
module tb_sha256_msg_feeder;
  localparam logic [2:0] C_IDLE = 3'b000, C_HOLD = 3'b001, C_LOAD = 3'b010;
  localparam logic [2:0] C_EXP  = 3'b011, C_WAIT = 3'b100, C_DONE = 3'b101;

  typedef struct {
    logic [6:0]  cnt;
    logic [31:0] data;
    logic        first;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        start_in = 1'b0, msg_valid_in = 1'b0, msg_last_in = 1'b0, comp_done_in = 1'b0;
  logic [31:0] msg_data_in = '0;
  logic [2:0]  msg_bytes_in = '0;
  logic        msg_ready_out, block_first_out, msg_done_out, busy_out;
  logic [2:0]  fsm_core_out;
  logic [6:0]  core_count_out;
  logic [31:0] me_data_out;

  int   checks = 0, failures = 0, done_cnt = 0;
  exp_t exp_q[$];
  logic [7:0] msg[$];

  sha256_msg_feeder dut (
    .clk(clk), .rst(rst), .start_in(start_in), .msg_valid_in(msg_valid_in),
    .msg_ready_out(msg_ready_out), .msg_data_in(msg_data_in), .msg_last_in(msg_last_in),
    .msg_bytes_in(msg_bytes_in), .fsm_core_out(fsm_core_out), .core_count_out(core_count_out),
    .me_data_out(me_data_out), .block_first_out(block_first_out), .comp_done_in(comp_done_in),
    .msg_done_out(msg_done_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Monitor: every LOAD beat must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (msg_done_out) done_cnt++;
      if (fsm_core_out == C_LOAD) begin
        if (exp_q.size() == 0) chk("extra_word", {57'd0, core_count_out}, 64'hFFFF);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("w_cnt", core_count_out, e.cnt);
          chk("w_data", me_data_out, e.data);
          chk("w_first", block_first_out, e.first);
        end
      end
    end
  end

  // Reference padding: 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
  task automatic model_push(output int nblk);
    logic [7:0]  p[$];
    logic [63:0] bl;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int j = 7; j >= 0; j--) p.push_back(bl[8*j +: 8]);
    for (int w = 0; w < p.size() / 4; w++) begin
      exp_t e;
      e.cnt   = 7'(w % 16);
      e.data  = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
      e.first = (w < 16);
      exp_q.push_back(e);
    end
    nblk = p.size() / 64;
  endtask

  task automatic wait_for(input logic [2:0] code, input int cnt, input string tag);
    int n = 0;
    while (!(fsm_core_out == code && (cnt < 0 || int'(core_count_out) == cnt)) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk({tag, "_timeout"}, 0, 1);
  endtask

  // Drives the message as words; don't-care bytes are random so padding must mask them.
  task automatic drive_msg(input int stall_idx, input int stall_len);
    int L = msg.size();
    int nw = (L + 3) / 4;
    int i = 0, st = 0, g = 0;
    if (nw == 0) nw = 1;
    while (i < nw && g < 2000) begin
      if (i == stall_idx && st < stall_len) begin
        msg_valid_in = 1'b0;
        st++;
        if (st >= 2) begin
          chk("stall_code", fsm_core_out, C_HOLD);
          chk("stall_cnt", core_count_out, 7'(stall_idx));
          chk("stall_data", me_data_out, {msg[4*i-4], msg[4*i-3], msg[4*i-2], msg[4*i-1]});
        end
      end else begin
        for (int j = 0; j < 4; j++)
          msg_data_in[31-8*j -: 8] = (4*i + j < L) ? msg[4*i+j] : 8'($urandom);
        msg_last_in  = (i == nw - 1);
        msg_bytes_in = (i == nw - 1) ? 3'(L - 4*i) : 3'd4;
        msg_valid_in = 1'b1;
        if (msg_ready_out) i++;
      end
      @(negedge clk);
      g++;
    end
    msg_valid_in = 1'b0;
    msg_last_in  = 1'b0;
  endtask

  task automatic respond(input int nblk, input int dly, input bit ex_pulse);
    for (int b = 0; b < nblk; b++) begin
      if (ex_pulse && b == 0) begin
        wait_for(C_EXP, 20, "exp20");
        comp_done_in = 1'b1;
        @(negedge clk);
        comp_done_in = 1'b0;
        chk("exp_ign_code", fsm_core_out, C_EXP);
        chk("exp_ign_cnt", core_count_out, 7'd21);
      end
      wait_for(C_WAIT, -1, "wait");
      if (dly > 0) begin
        repeat (dly) @(negedge clk);
        chk("wait_code", fsm_core_out, C_WAIT);
        chk("wait_cnt", core_count_out, 7'd0);
        chk("wait_rdy", msg_ready_out, 1'b0);
        chk("wait_busy", busy_out, 1'b1);
      end
      comp_done_in = 1'b1;
      @(negedge clk);
      comp_done_in = 1'b0;
      if (b == nblk - 1) begin
        chk("done_pulse", msg_done_out, 1'b1);
        chk("done_code", fsm_core_out, C_DONE);
      end else begin
        chk("mid_nodone", msg_done_out, 1'b0);
        chk("mid_code", fsm_core_out, C_HOLD);
      end
    end
  endtask

  task automatic run_msg(input int stall_idx, input int stall_len, input int dly, input bit ex_pulse);
    int nblk, d0;
    d0 = done_cnt;
    model_push(nblk);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    fork
      drive_msg(stall_idx, stall_len);
      respond(nblk, dly, ex_pulse);
    join
    @(negedge clk);
    chk("end_code", fsm_core_out, C_IDLE);
    chk("end_busy", busy_out, 1'b0);
    chk("end_done_cnt", done_cnt, d0 + 1);
    chk("end_sb_empty", exp_q.size(), 0);
  endtask

  task automatic load_msg(input int len, input int seed);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'(i * 7 + seed));
  endtask

  initial begin
    int nb;
    repeat (3) @(negedge clk);
    chk("rst_code", fsm_core_out, C_IDLE);
    chk("rst_cnt", core_count_out, 7'd0);
    chk("rst_data", me_data_out, 32'd0);
    chk("rst_rdy", msg_ready_out, 1'b0);
    chk("rst_busy", busy_out, 1'b0);
    chk("rst_first", block_first_out, 1'b0);
    chk("rst_done", msg_done_out, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    msg.delete(); msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_msg(-1, 0, 0, 1'b0);                 // "abc"
    msg.delete();
    run_msg(-1, 0, 2, 1'b0);                 // empty message
    load_msg(56, 1);  run_msg(-1, 0, 0, 1'b0);   // marker at k=14, two blocks
    load_msg(62, 3);  run_msg(-1, 0, 0, 1'b0);   // marker at k=15
    load_msg(64, 5);  run_msg(-1, 0, 0, 1'b0);   // full k=15 word, marker next block k=0
    load_msg(21, 9);  run_msg(5, 3, 10, 1'b1);   // stall, WAIT hold, EXPAND pulse ignored
    load_msg(130, 2); run_msg(-1, 0, 1, 1'b0);   // three blocks

    // Reset mid-EXPAND aborts silently.
    msg.delete(); msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    model_push(nb);
    nb = done_cnt;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    drive_msg(-1, 0);
    wait_for(C_EXP, 30, "exp30");
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_code", fsm_core_out, C_IDLE);
    chk("ar_cnt", core_count_out, 7'd0);
    chk("ar_data", me_data_out, 32'd0);
    chk("ar_rdy", msg_ready_out, 1'b0);
    chk("ar_busy", busy_out, 1'b0);
    chk("ar_first", block_first_out, 1'b0);
    chk("ar_done", msg_done_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ar_no_done", done_cnt, nb);
    chk("ar_sb_empty", exp_q.size(), 0);
    run_msg(-1, 0, 0, 1'b0);                 // "abc" again after abort

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
